// File: rtl/lm80c_pkg.sv
// Shared types for the LM80C SDRAM write path:
// address width default, grant encoding and arbiter FSM states.
package lm80c_pkg;

    localparam int AW_DEFAULT = 25;

    typedef enum logic [1:0] {
        GNT_ERS = 2'd0,
        GNT_DL  = 2'd1,
        GNT_CPU = 2'd2
    } gnt_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit push/pop; push while full is ignored.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wptr;
    logic [PW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) &&
                     (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (PW+1)'(1);
            if (do_pop)  rptr <= rptr + (PW+1)'(1);
        end
    end

endmodule

// File: rtl/sdram_wr_arbiter.sv
// Merges eraser, downloader and CPU RAM writes into one SDRAM write port.
// Fixed priority eraser > downloader > CPU, evaluated only while idle.
module sdram_wr_arbiter
    import lm80c_pkg::*;
#(
    parameter int ERS_DEPTH = 4,
    parameter int AW        = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ena,
    input  logic          ers_wr,
    input  logic [AW-1:0] ers_addr,
    input  logic [7:0]    ers_data,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_data,
    output logic          cpu_wait,
    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    output logic [7:0]    sdram_din,
    input  logic          sdram_ack,
    output logic          busy,
    output logic          overflow
);

    localparam int FW = AW + 8;

    logic [FW-1:0] ers_head;
    logic          ers_full;
    logic          ers_empty;
    logic          ers_push;
    logic          ers_pop;

    logic          dl_full;
    logic [AW-1:0] dl_slot_addr;
    logic [7:0]    dl_slot_data;
    logic          cpu_full;
    logic [AW-1:0] cpu_slot_addr;
    logic [7:0]    cpu_slot_data;

    state_t        state;
    state_t        next_state;
    gnt_t          gnt;
    gnt_t          next_gnt;
    logic [AW-1:0] next_addr;
    logic [7:0]    next_din;
    logic          done;

    assign ers_push = ena && ers_wr;
    assign ers_pop  = done && (gnt == GNT_ERS);

    sync_fifo #(
        .DEPTH (ERS_DEPTH),
        .W     (FW)
    ) u_ers_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (ers_push),
        .pop     (ers_pop),
        .din     ({ers_addr, ers_data}),
        .dout    (ers_head),
        .full    (ers_full),
        .empty   (ers_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dl_full       <= 1'b0;
            dl_slot_addr  <= '0;
            dl_slot_data  <= '0;
            cpu_full      <= 1'b0;
            cpu_slot_addr <= '0;
            cpu_slot_data <= '0;
            overflow      <= 1'b0;
        end else begin
            if (done && gnt == GNT_DL) dl_full <= 1'b0;
            if (dl_wr && !dl_full) begin
                dl_full      <= 1'b1;
                dl_slot_addr <= dl_addr;
                dl_slot_data <= dl_data;
            end
            if (done && gnt == GNT_CPU) cpu_full <= 1'b0;
            if (cpu_wr && !cpu_full) begin
                cpu_full      <= 1'b1;
                cpu_slot_addr <= cpu_addr;
                cpu_slot_data <= cpu_data;
            end
            if ((ers_push && ers_full) || (dl_wr && dl_full) ||
                (cpu_wr && cpu_full)) begin
                overflow <= 1'b1;
            end
        end
    end

    // An ack only counts once the request is actually visible.
    always_comb begin
        next_state = state;
        next_gnt   = gnt;
        next_addr  = sdram_addr;
        next_din   = sdram_din;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!ers_empty) begin
                    next_gnt   = GNT_ERS;
                    next_addr  = ers_head[FW-1:8];
                    next_din   = ers_head[7:0];
                    next_state = S_REQ;
                end else if (dl_full) begin
                    next_gnt   = GNT_DL;
                    next_addr  = dl_slot_addr;
                    next_din   = dl_slot_data;
                    next_state = S_REQ;
                end else if (cpu_full) begin
                    next_gnt   = GNT_CPU;
                    next_addr  = cpu_slot_addr;
                    next_din   = cpu_slot_data;
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (sdram_ack && sdram_req) begin
                    done       = 1'b1;
                    next_state = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            gnt        <= GNT_ERS;
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_req  <= 1'b0;
        end else begin
            state      <= next_state;
            gnt        <= next_gnt;
            sdram_addr <= next_addr;
            sdram_din  <= next_din;
            sdram_req  <= (state == S_REQ) && !done;
        end
    end

    assign cpu_wait = cpu_full;
    assign busy     = !ers_empty || dl_full || cpu_full ||
                      (state == S_REQ);

endmodule

// File: tb/tb_sdram_wr_arbiter.sv
// Directed bench for sdram_wr_arbiter with a simple SDRAM ack responder
// that logs every completed write.
module tb_sdram_wr_arbiter;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ena = 1'b0;
    logic          ers_wr = 1'b0;
    logic [AW-1:0] ers_addr = '0;
    logic [7:0]    ers_data = '0;
    logic          dl_wr = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_data = '0;
    logic          cpu_wait;
    logic          sdram_req;
    logic [AW-1:0] sdram_addr;
    logic [7:0]    sdram_din;
    logic          sdram_ack = 1'b0;
    logic          busy;
    logic          overflow;

    int total = 0;
    int bad = 0;

    logic [AW+7:0] wlog[$];
    bit            hold = 1'b0;
    bit            late_ack = 1'b0;
    int            ack_delay = 0;
    int            wait_cnt = 0;
    int            unstable = 0;
    int            req_seen = 0;
    logic [AW-1:0] cur_a;
    logic [7:0]    cur_d;

    sdram_wr_arbiter #(
        .ERS_DEPTH (4),
        .AW        (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ena        (ena),
        .ers_wr     (ers_wr),
        .ers_addr   (ers_addr),
        .ers_data   (ers_data),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_wait   (cpu_wait),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_din  (sdram_din),
        .sdram_ack  (sdram_ack),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Acks ack_delay+1 cycles after req is seen; logs the acked write.
    always @(negedge clk) begin
        sdram_ack = late_ack;
        if (sdram_req && !hold) begin
            req_seen++;
            if (wait_cnt == 0) begin
                cur_a = sdram_addr;
                cur_d = sdram_din;
            end else if (sdram_addr !== cur_a || sdram_din !== cur_d) begin
                unstable++;
            end
            if (wait_cnt == ack_delay) begin
                sdram_ack = 1'b1;
                wlog.push_back({sdram_addr, sdram_din});
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && !sdram_req) return;
        end
        total++;
        bad++;
        $display("FAIL %s idle timeout: busy=%0b req=%0b required idle",
                 tag, busy, sdram_req);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sdram_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_req got=%b exp=0", sdram_req);
        end
        total++;
        if (sdram_addr !== '0) begin
            bad++;
            $display("FAIL rst_addr got=%h exp=0", sdram_addr);
        end
        total++;
        if (sdram_din !== 8'h00) begin
            bad++;
            $display("FAIL rst_din got=%h exp=0", sdram_din);
        end
        total++;
        if (cpu_wait !== 1'b0) begin
            bad++;
            $display("FAIL rst_cpu_wait got=%b exp=0", cpu_wait);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL rst_overflow got=%b exp=0", overflow);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_ers_burst();
        logic [AW+7:0] got;
        logic [AW+7:0] exp;
        wlog.delete();
        ers_wr = 1'b1;
        ers_data = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ena = 1'b1;
            ers_addr = AW'(32'h10000 + i);
            @(negedge clk);
            ena = 1'b0;
            repeat (2) @(negedge clk);
        end
        ers_wr = 1'b0;
        wait_idle(100, "burst");
        total++;
        if (wlog.size() != 16) begin
            bad++;
            $display("FAIL burst_count got=%0d exp=16", wlog.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < wlog.size()) ? wlog[i] : 'x;
            exp = {AW'(32'h10000 + i), 8'hFF};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL burst_wr%0d got=%h exp=%h", i, got, exp);
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL burst_overflow got=%b exp=0", overflow);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL burst_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [AW+7:0] exp [3];
        logic [AW+7:0] got;
        int wait_err;
        int cyc;
        exp[0] = {AW'(32'h10000), 8'hFF};
        exp[1] = {AW'(32'h00100), 8'h3E};
        exp[2] = {AW'(32'h12345), 8'hA5};
        wlog.delete();
        @(negedge clk);
        ena = 1'b1;
        ers_wr = 1'b1;
        ers_addr = AW'(32'h10000);
        ers_data = 8'hFF;
        dl_wr = 1'b1;
        dl_addr = AW'(32'h00100);
        dl_data = 8'h3E;
        cpu_wr = 1'b1;
        cpu_addr = AW'(32'h12345);
        cpu_data = 8'hA5;
        @(negedge clk);
        ena = 1'b0;
        ers_wr = 1'b0;
        dl_wr = 1'b0;
        cpu_wr = 1'b0;
        wait_err = 0;
        cyc = 0;
        while (wlog.size() < 3 && cyc < 50) begin
            if (cpu_wait !== 1'b1) wait_err++;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (wait_err != 0) begin
            bad++;
            $display("FAIL simul_cpu_wait low_cycles=%0d exp=0", wait_err);
        end
        wait_idle(20, "simul");
        total++;
        if (cpu_wait !== 1'b0) begin
            bad++;
            $display("FAIL simul_cpu_wait_end got=%b exp=0", cpu_wait);
        end
        total++;
        if (wlog.size() != 3) begin
            bad++;
            $display("FAIL simul_count got=%0d exp=3", wlog.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < wlog.size()) ? wlog[i] : 'x;
            total++;
            if (got !== exp[i]) begin
                bad++;
                $display("FAIL simul_order%0d got=%h exp=%h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_ack_latency();
        logic [AW+7:0] got;
        wlog.delete();
        ack_delay = 6;
        req_seen = 0;
        unstable = 0;
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_addr = AW'(32'h00042);
        cpu_data = 8'h5A;
        @(negedge clk);
        cpu_wr = 1'b0;
        wait_idle(40, "latency");
        ack_delay = 0;
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL lat_stable unstable=%0d exp=0", unstable);
        end
        total++;
        if (req_seen != 7) begin
            bad++;
            $display("FAIL lat_req_cycles got=%0d exp=7", req_seen);
        end
        got = (wlog.size() > 0) ? wlog[0] : 'x;
        total++;
        if (wlog.size() != 1 || got !== {AW'(32'h00042), 8'h5A}) begin
            bad++;
            $display("FAIL lat_write n=%0d got=%h exp=%h", wlog.size(), got,
                     {AW'(32'h00042), 8'h5A});
        end
    endtask

    task automatic test_cpu_violation();
        logic [AW+7:0] got;
        int sticky_err;
        wlog.delete();
        hold = 1'b1;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL viol_pre_overflow got=%b exp=0", overflow);
        end
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_addr = AW'(32'h00200);
        cpu_data = 8'h11;
        @(negedge clk);
        cpu_wr = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_wait !== 1'b1) begin
            bad++;
            $display("FAIL viol_cpu_wait got=%b exp=1", cpu_wait);
        end
        cpu_wr = 1'b1;
        cpu_addr = AW'(32'h00201);
        cpu_data = 8'h22;
        @(negedge clk);
        cpu_wr = 1'b0;
        @(negedge clk);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL viol_overflow got=%b exp=1", overflow);
        end
        hold = 1'b0;
        wait_idle(20, "viol");
        got = (wlog.size() > 0) ? wlog[0] : 'x;
        total++;
        if (wlog.size() != 1 || got !== {AW'(32'h00200), 8'h11}) begin
            bad++;
            $display("FAIL viol_write n=%0d got=%h exp=%h", wlog.size(), got,
                     {AW'(32'h00200), 8'h11});
        end
        sticky_err = 0;
        repeat (5) begin
            @(negedge clk);
            if (overflow !== 1'b1) sticky_err++;
        end
        total++;
        if (sticky_err != 0) begin
            bad++;
            $display("FAIL viol_sticky low_cycles=%0d exp=0", sticky_err);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [AW+7:0] got;
        logic [AW+7:0] exp;
        do_reset();
        @(negedge clk);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL fifo_pre_overflow got=%b exp=0", overflow);
        end
        wlog.delete();
        hold = 1'b1;
        ers_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ena = 1'b1;
            ers_addr = AW'(32'h20000 + i);
            ers_data = 8'(8'h80 + i);
            @(negedge clk);
        end
        ena = 1'b0;
        ers_wr = 1'b0;
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL fifo_overflow got=%b exp=1", overflow);
        end
        hold = 1'b0;
        wait_idle(50, "fifo");
        total++;
        if (wlog.size() != 4) begin
            bad++;
            $display("FAIL fifo_count got=%0d exp=4", wlog.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < wlog.size()) ? wlog[i] : 'x;
            exp = {AW'(32'h20000 + i), 8'(8'h80 + i)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL fifo_wr%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        int cyc;
        do_reset();
        wlog.delete();
        hold = 1'b1;
        @(negedge clk);
        dl_wr = 1'b1;
        dl_addr = AW'(32'h00300);
        dl_data = 8'h77;
        @(negedge clk);
        dl_wr = 1'b0;
        cyc = 0;
        while (sdram_req !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (sdram_req !== 1'b1) begin
            bad++;
            $display("FAIL mid_req_rise got=%b exp=1", sdram_req);
        end
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (sdram_req !== 1'b0) begin
            bad++;
            $display("FAIL mid_req_drop got=%b exp=0", sdram_req);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_busy got=%b exp=0", busy);
        end
        reset_n = 1'b1;
        #1 late_ack = 1'b1;
        @(negedge clk);
        #1 late_ack = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (sdram_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_late_ack req=%b busy=%b exp=0/0", sdram_req, busy);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_overflow got=%b exp=0", overflow);
        end
        hold = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (wlog.size() != 0) begin
            bad++;
            $display("FAIL mid_no_write got=%0d exp=0", wlog.size());
        end
    endtask

    initial begin
        test_reset();
        test_ers_burst();
        test_simultaneous();
        test_ack_latency();
        test_cpu_violation();
        test_fifo_overflow();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
